// File: rtl/bf_exec_engine_if.sv
// Bus bundle between the BF engine and its program ROM, data RAM and SFR port.
// master = engine side, slave = memory/peripheral side.
interface bf_exec_engine_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned PTR_W  = 8,
  parameter int unsigned PC_W   = 11
);
  logic [PC_W-1:0]   rom_addr;
  logic [2:0]        rom_code;
  logic              rom_overrun;
  logic [PTR_W-1:0]  ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic [PTR_W-1:0]  sfr_addr;
  logic              sfr_wr;
  logic              sfr_rd;
  logic [DATA_W-1:0] sfr_wdata;
  logic [DATA_W-1:0] sfr_rdata;
  logic              sfr_ready;

  modport master (
    output rom_addr, ram_addr, ram_we, ram_wdata, sfr_addr, sfr_wr, sfr_rd, sfr_wdata,
    input  rom_code, rom_overrun, ram_rdata, sfr_rdata, sfr_ready
  );

  modport slave (
    input  rom_addr, ram_addr, ram_we, ram_wdata, sfr_addr, sfr_wr, sfr_rd, sfr_wdata,
    output rom_code, rom_overrun, ram_rdata, sfr_rdata, sfr_ready
  );
endinterface

// File: rtl/bf_exec_engine.sv
// Single-clock Brainfuck execution engine with hardware bracket resolution.
// Define BF_LOOP_STACK_EN to add a loop-return stack instead of backward scanning.
module bf_exec_engine #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned PTR_W       = 8,
  parameter int unsigned PC_W        = 11,
  parameter int unsigned NEST_W      = 8,
  parameter int unsigned STACK_DEPTH = 16
) (
  input  logic                clk_i,
  input  logic                nrst_i,
  input  logic                run_i,
  bf_exec_engine_if.master    bus,
  output logic                halted_o,
  output logic                fault_o
);

  localparam logic [2:0] OpRight = 3'd0;
  localparam logic [2:0] OpLeft  = 3'd1;
  localparam logic [2:0] OpInc   = 3'd2;
  localparam logic [2:0] OpDec   = 3'd3;
  localparam logic [2:0] OpOut   = 3'd4;
  localparam logic [2:0] OpIn    = 3'd5;
  localparam logic [2:0] OpOpen  = 3'd6;
  localparam logic [2:0] OpClose = 3'd7;

  typedef enum logic [2:0] {
    StFetch, StExec, StIoWait, StWrBack, StScanF, StScanB, StHalt
  } state_e;

  if (STACK_DEPTH < 1) begin : g_bad_depth
    $error("STACK_DEPTH must be at least 1");
  end

  state_e              state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;
  logic [NEST_W-1:0]   depth_q, depth_d;
  logic [2:0]          op_q, op_d;
  logic [DATA_W-1:0]   io_data_q, io_data_d;
  logic                halted_q, halted_d;
  logic                fault_q, fault_d;
  logic                ram_we;
  logic [DATA_W-1:0]   ram_wdata;
  logic                halt_req, fault_req, scan_match, cell_zero;

`ifdef BF_LOOP_STACK_EN
  localparam int unsigned SpW  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IdxW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PC_W-1:0] stack_q [STACK_DEPTH];
  logic [SpW-1:0]  sp_q, sp_d, sp_m1;
  logic            push;

  assign sp_m1 = sp_q - 1'b1;

  always_ff @(posedge clk_i) begin
    if (push) stack_q[sp_q[IdxW-1:0]] <= pc_q;
  end
`endif

  assign cell_zero = (bus.ram_rdata == '0);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ptr_d      = ptr_q;
    depth_d    = depth_q;
    op_d       = op_q;
    io_data_d  = io_data_q;
    halted_d   = halted_q;
    fault_d    = fault_q;
    ram_we     = 1'b0;
    ram_wdata  = '0;
    halt_req   = 1'b0;
    fault_req  = 1'b0;
    scan_match = 1'b0;
`ifdef BF_LOOP_STACK_EN
    sp_d = sp_q;
    push = 1'b0;
`endif
    unique case (state_q)
      StFetch: begin
        if (bus.rom_overrun) begin
          halt_req = 1'b1;
        end else if (run_i) begin
          op_d    = bus.rom_code;
          state_d = StExec;
        end
      end
      StExec: begin
        state_d = StFetch;
        pc_d    = pc_q + 1'b1;
        unique case (op_q)
          OpRight: ptr_d = ptr_q + 1'b1;
          OpLeft:  ptr_d = ptr_q - 1'b1;
          OpInc: begin
            ram_we    = 1'b1;
            ram_wdata = bus.ram_rdata + 1'b1;
          end
          OpDec: begin
            ram_we    = 1'b1;
            ram_wdata = bus.ram_rdata - 1'b1;
          end
          OpOut: begin
            io_data_d = bus.ram_rdata;
            pc_d      = pc_q;
            state_d   = StIoWait;
          end
          OpIn: begin
            pc_d    = pc_q;
            state_d = StIoWait;
          end
          OpOpen: begin
            if (cell_zero) begin
              depth_d = '0;
              state_d = StScanF;
            end
`ifdef BF_LOOP_STACK_EN
            else if (sp_q == SpW'(STACK_DEPTH)) begin
              fault_req = 1'b1;
            end else begin
              push = 1'b1;
              sp_d = sp_q + 1'b1;
            end
`endif
          end
          OpClose: begin
`ifdef BF_LOOP_STACK_EN
            if (sp_q == '0) begin
              fault_req = 1'b1;
            end else if (!cell_zero) begin
              pc_d = stack_q[sp_m1[IdxW-1:0]] + 1'b1;
            end else begin
              sp_d = sp_m1;
            end
`else
            if (!cell_zero) begin
              if (pc_q == '0) begin
                fault_req = 1'b1;
              end else begin
                depth_d = '0;
                pc_d    = pc_q - 1'b1;
                state_d = StScanB;
              end
            end
`endif
          end
        endcase
      end
      StIoWait: begin
        if (bus.sfr_ready) begin
          if (op_q == OpIn) begin
            // RAM write is deferred a cycle so it never overlaps the SFR strobe
            io_data_d = bus.sfr_rdata;
            state_d   = StWrBack;
          end else begin
            pc_d    = pc_q + 1'b1;
            state_d = StFetch;
          end
        end
      end
      StWrBack: begin
        ram_we    = 1'b1;
        ram_wdata = io_data_q;
        pc_d      = pc_q + 1'b1;
        state_d   = StFetch;
      end
      StScanF: begin
        if (bus.rom_overrun) begin
          fault_req = 1'b1;
        end else begin
          pc_d = pc_q + 1'b1;
          if (bus.rom_code == OpOpen) begin
            if (&depth_q) fault_req = 1'b1;
            else          depth_d = depth_q + 1'b1;
          end else if (bus.rom_code == OpClose) begin
            if (depth_q == '0) state_d = StFetch;
            else               depth_d = depth_q - 1'b1;
          end
        end
      end
      StScanB: begin
        if (bus.rom_code == OpClose) begin
          if (&depth_q) fault_req = 1'b1;
          else          depth_d = depth_q + 1'b1;
        end else if (bus.rom_code == OpOpen) begin
          if (depth_q == '0) begin
            scan_match = 1'b1;
            pc_d       = pc_q + 1'b1;
            state_d    = StFetch;
          end else begin
            depth_d = depth_q - 1'b1;
          end
        end
        if (!scan_match) begin
          if (pc_q == '0) fault_req = 1'b1;
          else            pc_d = pc_q - 1'b1;
        end
      end
      default: ;
    endcase

    if (halt_req || fault_req) begin
      state_d  = StHalt;
      halted_d = 1'b1;
    end
    // Faulting leaves pc pointing at the offending location
    if (fault_req) begin
      fault_d = 1'b1;
      pc_d    = pc_q;
      depth_d = depth_q;
`ifdef BF_LOOP_STACK_EN
      sp_d = sp_q;
      push = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge nrst_i) begin
    if (!nrst_i) begin
      state_q   <= StFetch;
      pc_q      <= '0;
      ptr_q     <= '0;
      depth_q   <= '0;
      op_q      <= '0;
      io_data_q <= '0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
`ifdef BF_LOOP_STACK_EN
      sp_q      <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ptr_q     <= ptr_d;
      depth_q   <= depth_d;
      op_q      <= op_d;
      io_data_q <= io_data_d;
      halted_q  <= halted_d;
      fault_q   <= fault_d;
`ifdef BF_LOOP_STACK_EN
      sp_q      <= sp_d;
`endif
    end
  end

  assign bus.rom_addr  = pc_q;
  assign bus.ram_addr  = ptr_q;
  assign bus.ram_we    = ram_we;
  assign bus.ram_wdata = ram_wdata;
  assign bus.sfr_addr  = ptr_q;
  assign bus.sfr_wr    = (state_q == StIoWait) && (op_q == OpOut);
  assign bus.sfr_rd    = (state_q == StIoWait) && (op_q == OpIn);
  assign bus.sfr_wdata = io_data_q;
  assign halted_o      = halted_q;
  assign fault_o       = fault_q;

endmodule
